// File: rtl/pmod_als_spi_emulator_if.sv
// Pin and load-port bundle for the Pmod ALS SPI emulator.
// The slave modport is the emulator side; master is the SPI master / data source side.
interface pmod_als_spi_emulator_if #(
  parameter int WIDTH = 16
) ();
  logic             cs;
  logic             sck;
  logic             sdo;
  logic             sdo_oe;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             busy;
  logic             frame_done;
  logic             frame_abort;

  modport slave (
    input  cs, sck, load_data, load_valid,
    output sdo, sdo_oe, load_ready, busy, frame_done, frame_abort
  );

  modport master (
    output cs, sck, load_data, load_valid,
    input  sdo, sdo_oe, load_ready, busy, frame_done, frame_abort
  );
endinterface

// File: rtl/pmod_als_spi_emulator.sv
// Emulates the Pmod ALS sensor: shifts a WIDTH-bit frame MSB-first on sdo,
// clocked by the master's asynchronous cs/sck, with a valid/ready holding register.
module pmod_als_spi_emulator #(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = 16'h0000
) (
  input logic                    clock,
  input logic                    reset,
  pmod_als_spi_emulator_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_TAIL      = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sck_prev_q, sck_prev_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic                   pending_q, pending_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   sdo_q, sdo_d;
  logic                   sdo_oe_q, sdo_oe_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_abort_q, frame_abort_d;

  logic cs_s;
  logic sck_s;
  logic cs_fall_s;
  logic cs_rise_s;
  logic sck_fall_s;
  logic load_fire_s;
  logic start_s;

  // Synchronizer shift and edge detection on the last two synchronized samples.
  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
    cs_s       = cs_sync_q[SYNC_STAGES-1];
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    cs_prev_d  = cs_s;
    sck_prev_d = sck_s;
    cs_fall_s  = cs_prev_q & ~cs_s;
    cs_rise_s  = ~cs_prev_q & cs_s;
    sck_fall_s = sck_prev_q & ~sck_s & ~cs_s;
  end

  // Frame FSM: next state, shifter, bit count and event pulses.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    count_d       = count_q;
    start_s       = 1'b0;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    case (state_q)
      ST_WAIT_IDLE: begin
        // Synchronizers restart at 1, so cs is trusted only after they refill.
        if ((count_q >= CNT_SETTLE) && cs_s && cs_prev_q) begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
        end else if (count_q < CNT_SETTLE) begin
          count_d = count_q + CNT_ONE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_IDLE: begin
        if (cs_fall_s) begin
          start_s = 1'b1;
          shift_d = hold_q;
          count_d = CNT_ZERO;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_s) begin
          frame_abort_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (sck_fall_s) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          count_d = count_q + CNT_ONE;
          if (count_d == CNT_FULL) begin
            frame_done_d = 1'b1;
            state_d      = ST_TAIL;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_TAIL: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TAIL;
        end
      end
      default: begin
        state_d = ST_WAIT_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
  end

  // Holding register; a load coinciding with frame start re-arms pending for the next frame.
  always_comb begin
    load_fire_s = bus.load_valid & ~pending_q;
    if (load_fire_s) begin
      hold_d    = bus.load_data;
      pending_d = 1'b1;
    end else if (start_s) begin
      hold_d    = hold_q;
      pending_d = 1'b0;
    end else begin
      hold_d    = hold_q;
      pending_d = pending_q;
    end
  end

  // Pin-side outputs follow the next state so they register on the same edge.
  always_comb begin
    sdo_d    = (state_d == ST_SHIFT) ? shift_d[WIDTH-1] : 1'b0;
    sdo_oe_d = (state_d == ST_SHIFT) || (state_d == ST_TAIL);
    busy_d   = (state_d == ST_SHIFT) || (state_d == ST_TAIL);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_WAIT_IDLE;
      cs_sync_q     <= {SYNC_STAGES{1'b1}};
      sck_sync_q    <= {SYNC_STAGES{1'b1}};
      cs_prev_q     <= 1'b1;
      sck_prev_q    <= 1'b1;
      hold_q        <= RESET_VALUE;
      pending_q     <= 1'b0;
      shift_q       <= {WIDTH{1'b0}};
      count_q       <= CNT_ZERO;
      sdo_q         <= 1'b0;
      sdo_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_sync_q     <= cs_sync_d;
      sck_sync_q    <= sck_sync_d;
      cs_prev_q     <= cs_prev_d;
      sck_prev_q    <= sck_prev_d;
      hold_q        <= hold_d;
      pending_q     <= pending_d;
      shift_q       <= shift_d;
      count_q       <= count_d;
      sdo_q         <= sdo_d;
      sdo_oe_q      <= sdo_oe_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign bus.sdo         = sdo_q;
  assign bus.sdo_oe      = sdo_oe_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_abort = frame_abort_q;
  assign bus.load_ready  = ~pending_q;

endmodule

// File: tb/tb_pmod_als_spi_emulator.sv
// Directed bench: acts as SPI master (16-clock sck period) and data source,
// comparing received frames and status against hand-computed values.
module tb_pmod_als_spi_emulator;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   done_cnt;
  int   abort_cnt;

  pmod_als_spi_emulator_if #(.WIDTH(16)) bus ();

  pmod_als_spi_emulator #(
    .WIDTH      (16),
    .SYNC_STAGES(2),
    .RESET_VALUE(16'h0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    done_cnt  = 0;
    abort_cnt = 0;
  end

  // Pulse counters sampled away from the active edge.
  always @(negedge clock) begin
    if (bus.frame_done)  done_cnt  <= done_cnt + 1;
    if (bus.frame_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] value);
    logic ok;
    ok = 1'b0;
    bus.load_data  = value;
    bus.load_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (bus.load_ready) begin
        ok = 1'b1;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    bus.load_valid = 1'b0;
    check_eq("load_handshake", {31'd0, ok}, 32'd1);
  endtask

  // One cs-low window with nfalls sck falls; a bit is sampled at the end of each high phase.
  task automatic run_frame(input int nfalls, output logic [31:0] rx,
                           output logic oe_all, output logic rdy_first);
    rx        = 32'd0;
    oe_all    = 1'b1;
    rdy_first = 1'b0;
    @(negedge clock);
    bus.cs = 1'b0;
    for (int i = 0; i < nfalls; i++) begin
      repeat (8) @(negedge clock);
      rx     = {rx[30:0], bus.sdo};
      oe_all = oe_all & bus.sdo_oe;
      if (i == 0) rdy_first = bus.load_ready;
      bus.sck = 1'b0;
      repeat (8) @(negedge clock);
      bus.sck = 1'b1;
    end
    repeat (8) @(negedge clock);
    oe_all = oe_all & bus.sdo_oe;
    bus.cs = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  logic [31:0] rx, rx2;
  logic        oe, rdy, oe2, rdy2, bad, busy_at;
  int          d0, a0, c;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.cs = 1'b1;
    bus.sck = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data = 16'h0000;
    repeat (3) @(negedge clock);
    check_eq("reset_outputs", {26'd0, bus.sdo, bus.sdo_oe, bus.busy, bus.frame_done,
             bus.frame_abort, bus.load_ready}, 32'h0000_0001);
    reset = 1'b0;
    repeat (8) @(negedge clock);

    // No load since reset: RESET_VALUE twice, then one load resent twice.
    run_frame(16, rx, oe, rdy);
    check_eq("noload_f1", rx, 32'h0000_0000);
    run_frame(16, rx, oe, rdy);
    check_eq("noload_f2", rx, 32'h0000_0000);
    do_load(16'h0FF0);
    run_frame(16, rx, oe, rdy);
    check_eq("0ff0_f1", rx, 32'h0000_0FF0);
    run_frame(16, rx, oe, rdy);
    check_eq("0ff0_f2", rx, 32'h0000_0FF0);

    // Basic frame.
    do_load(16'hA5C3);
    check_eq("a5c3_ready_pending", {31'd0, bus.load_ready}, 32'd0);
    d0 = done_cnt;
    run_frame(16, rx, oe, rdy);
    check_eq("a5c3_rx", rx, 32'h0000_A5C3);
    check_eq("a5c3_done_pulses", done_cnt - d0, 32'd1);
    check_eq("a5c3_ready_at_start", {31'd0, rdy}, 32'd1);
    check_eq("a5c3_oe", {31'd0, oe}, 32'd1);

    // Abort after 5 bits, then the consumed value is resent whole.
    do_load(16'hFFFF);
    d0 = done_cnt;
    a0 = abort_cnt;
    run_frame(5, rx, oe, rdy);
    check_eq("abort_rx5", rx, 32'h0000_001F);
    check_eq("abort_pulses", abort_cnt - a0, 32'd1);
    check_eq("abort_no_done", done_cnt - d0, 32'd0);
    run_frame(16, rx, oe, rdy);
    check_eq("abort_resend", rx, 32'h0000_FFFF);

    // Over-clocked window: 20 falls, extra bits read zero, oe held.
    do_load(16'h8001);
    d0 = done_cnt;
    run_frame(20, rx, oe, rdy);
    check_eq("over_rx20", rx, 32'h0008_0010);
    check_eq("over_oe", {31'd0, oe}, 32'd1);
    check_eq("over_done", done_cnt - d0, 32'd1);

    // Reset mid-frame with cs held low.
    @(negedge clock);
    bus.cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (8) @(negedge clock);
      bus.sck = 1'b0;
      repeat (8) @(negedge clock);
      bus.sck = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if ((i % 8) == 7) bus.sck = ~bus.sck;
      @(negedge clock);
      bad = bad | bus.sdo | bus.busy | bus.sdo_oe;
    end
    check_eq("rstmid_quiet", {31'd0, bad}, 32'd0);
    check_eq("rstmid_ready", {31'd0, bus.load_ready}, 32'd1);
    do_load(16'h3C5A);
    bus.sck = 1'b1;
    bus.cs = 1'b1;
    repeat (8) @(negedge clock);
    run_frame(16, rx, oe, rdy);
    check_eq("rstmid_next", rx, 32'h0000_3C5A);

    // sck toggles with cs high are ignored.
    d0 = done_cnt;
    a0 = abort_cnt;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.sck = ~bus.sck;
      repeat (4) @(negedge clock);
      bad = bad | bus.busy | bus.sdo_oe | bus.sdo;
    end
    bus.sck = 1'b1;
    repeat (4) @(negedge clock);
    check_eq("sck_cs_high_quiet", {31'd0, bad}, 32'd0);
    check_eq("sck_cs_high_pulses", (done_cnt - d0) + (abort_cnt - a0), 32'd0);

    // load_valid held across frame start: accepted the cycle after, next frame carries it.
    do_load(16'h1234);
    c = 0;
    busy_at = 1'b0;
    fork
      run_frame(16, rx, oe, rdy);
      begin
        @(negedge clock);
        bus.load_data = 16'h5678;
        bus.load_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
          @(negedge clock);
          c++;
          if (bus.load_ready) begin
            busy_at = bus.busy;
            break;
          end
        end
        @(negedge clock);
        bus.load_valid = 1'b0;
      end
    join
    check_eq("start_load_cycle", c, 32'd3);
    check_eq("start_load_busy", {31'd0, busy_at}, 32'd1);
    check_eq("start_load_rx", rx, 32'h0000_1234);
    check_eq("start_load_pending", {31'd0, bus.load_ready}, 32'd0);
    run_frame(16, rx2, oe2, rdy2);
    check_eq("start_load_next", rx2, 32'h0000_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmod_als_spi_emulator.md
Name: pmod_als_spi_emulator

Overview:
- SPI peripheral-side transmitter: emulates the Pmod ALS light sensor so the existing SPI receiver can be exercised on-board or in simulation without the real part.
- Watches the master's cs/sck (asynchronous to clock), shifts out a 16-bit frame MSB-first on sdo.
- Frame data comes from a local valid/ready load port (test pattern generator or register).

Parameters:
WIDTH, 16, bits per frame; equals sck falling edges per cs-low window.
SYNC_STAGES, 2, synchronizer flops on cs and sck (min 2).
RESET_VALUE, 16'h0000, frame data until the first load.

Ports:
clock  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
cs  input  1  chip select from master, active low, asynchronous.
sck  input  1  serial clock from master, idles high, asynchronous.
sdo  output  1  serial data to master.
sdo_oe  output  1  drive enable for sdo pad; 1 only while a frame is active.
load_data  input  WIDTH  next frame value.
load_valid  input  1  load_data is valid.
load_ready  output  1  holding register can accept.
busy  output  1  frame in progress.
frame_done  output  1  one-clock pulse after the WIDTH-th bit is shifted.
frame_abort  output  1  one-clock pulse when cs rises before WIDTH bits.

Behaviour:
- Synchronizers: cs and sck each pass through SYNC_STAGES flops, reset to 1. Edges are detected from the last two synchronized samples.
- Holding register hold, reset to RESET_VALUE. Its pending flag resets to 0.
- load_ready = ~pending.
- A load (load_valid & load_ready) writes hold and sets pending.
- pending clears when hold is copied into the shifter at frame start. On the same cycle, load_ready is 0, so no load occurs.
- If no load arrives between frames, the last hold value is sent again.
- FSM:
  - WAIT_IDLE: entered on reset. Moves to IDLE once synchronized cs = 1. This ignores a frame already in progress when reset releases.
  - IDLE: on cs falling edge, copy hold into shift, set bit count to 0, go to SHIFT.
  - SHIFT:
    - On each sck falling edge (cs low), shift left with 0 fill and increment the count.
    - When the count reaches WIDTH, pulse frame_done and go to TAIL.
    - On cs rising edge, pulse frame_abort and go to IDLE.
  - TAIL: sdo = 0 for any further sck edges (no wrap, no reload). On cs rising edge, go to IDLE with no pulse.
- sdo = shift[WIDTH-1] in SHIFT, otherwise 0. sdo is registered.
  - The first bit appears 1 + SYNC_STAGES clocks after the cs fall.
  - Each following bit appears 1 + SYNC_STAGES clocks after the sck fall.
  - With a master sampling at the end of each 8-clock sck-high phase, this gives at least 4 clocks of setup.
- sdo_oe = 1 in SHIFT and TAIL.
- busy = 1 in SHIFT and TAIL.
- sck edges while cs is high are ignored in every state.
- A cs fall and an sck fall detected on the same clock: the frame starts and that sck edge is ignored.
- Reset values:
  - sdo, sdo_oe, busy, frame_done, frame_abort = 0.
  - load_ready = 1.
  - shift = 0, count = 0, state = WAIT_IDLE.
- Reset mid-frame: all of the above are restored. The rest of that cs-low window is ignored via WAIT_IDLE.

Test Plan:
- Load 16'hA5C3, then run master timing (sck period 16 clocks, cs low 256 clocks) -> received 16'hA5C3; frame_done pulses once; load_ready returns to 1 at frame start.
- No load after reset, two frames -> both read 16'h0000. Then load 16'h0FF0 once, run two frames -> both read 16'h0FF0.
- cs raised after 5 sck falls with data 16'hFFFF -> frame_abort pulse, no frame_done. The next frame resends 16'hFFFF (already consumed, not reloaded) -> the full 16 ones are received.
- 20 sck falls in one cs-low window, data 16'h8001 -> first 16 bits = 16'h8001; bits 17-20 = 0; sdo_oe stays 1 until cs rises.
- reset held for 3 clocks mid-frame, cs still low -> no sdo activity, busy = 0 until cs rises. The next frame transmits the held value correctly.
- Toggle sck with cs high, and assert load_valid on the frame-start clock -> no shifting or pulses from the sck toggles. The load is accepted on the following cycle, and the next frame carries the new value.
